// File: rtl/spi_regs_pkg.sv
// Shared constants and types for the SPI register-file front end of the PWM peripheral.
package spi_regs_pkg;

  localparam logic [6:0] ADDR_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY   = 7'h04;

  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } spi_state_e;

  // A frame is a write only if the R/W bit is set and the address is implemented.
  function automatic logic frame_is_write(input logic [15:0] frame, input logic [6:0] max_addr);
    return frame[15] && (frame[14:8] <= max_addr);
  endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pins plus the register outputs and FSM debug state of the PWM register front end.
interface spi_peripheral_if;
  import spi_regs_pkg::*;

  // SPI pins are driven by the external controller; ncs/sclk/copi are asynchronous to clk.
  // No valid/ready handshake exists here: wr_strobe is a one-cycle pulse qualifying
  // the register outputs, which are registered and hold their value between writes.
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  spi_state_e state;

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe, state
  );

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_strobe, state
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset value.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only receiver that loads the five 8-bit PWM control registers.
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter logic [6:0] MAX_ADDR    = 7'h04,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_peripheral_if.slave  bus
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [7:0] SETTLE    = 8'(SYNC_STAGES + 1);

  logic ncs_s, sclk_s, copi_s;
  logic ncs_prev, sclk_prev;
  logic ncs_fall, ncs_rise, sclk_rise;
  logic [7:0] settle_cnt;
  logic settled;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(bus.ncs), .q(ncs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(bus.copi), .q(copi_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_prev  <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      ncs_prev  <= ncs_s;
      sclk_prev <= sclk_s;
    end
  end

  // The ncs chain resets high, so a controller still holding ncs low at reset release
  // would look like a fresh falling edge; edges are ignored until the chain has flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 8'd1;
    end
  end

  assign settled   = (settle_cnt == SETTLE);
  assign ncs_fall  = settled & ncs_prev & ~ncs_s;
  assign ncs_rise  = settled & ~ncs_prev & ncs_s;
  assign sclk_rise = sclk_s & ~sclk_prev;

  spi_state_e state_q, state_d;
  logic clear_frame, shift_en, commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_frame = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          clear_frame = 1'b1;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [15:0] shift_q;
  logic [4:0]  bit_cnt;
  logic        overrun;

  // The counter saturates at 16; overrun remembers that extra bits arrived so that a
  // long frame is rejected even though the count alone looks complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else if (clear_frame) begin
      shift_q <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else if (shift_en) begin
      if (bit_cnt < FRAME_CNT) begin
        shift_q <= {shift_q[14:0], copi_s};
        bit_cnt <= bit_cnt + 5'd1;
      end else begin
        overrun <= 1'b1;
      end
    end
  end

  logic write_ok;
  assign write_ok = commit && (bit_cnt == FRAME_CNT) && !overrun &&
                    frame_is_write(shift_q, MAX_ADDR);

  logic [7:0] regs_q [NUM_REGS];
  logic       wr_strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_strobe_q <= 1'b0;
    end else begin
      wr_strobe_q <= write_ok;
      if (write_ok) begin
        case (shift_q[14:8])
          ADDR_OUT_LO: regs_q[0] <= shift_q[7:0];
          ADDR_OUT_HI: regs_q[1] <= shift_q[7:0];
          ADDR_PWM_LO: regs_q[2] <= shift_q[7:0];
          ADDR_PWM_HI: regs_q[3] <= shift_q[7:0];
          ADDR_DUTY:   regs_q[4] <= shift_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.en_reg_out_7_0  = regs_q[0];
  assign bus.en_reg_out_15_8 = regs_q[1];
  assign bus.en_reg_pwm_7_0  = regs_q[2];
  assign bus.en_reg_pwm_15_8 = regs_q[3];
  assign bus.pwm_duty_cycle  = regs_q[4];
  assign bus.wr_strobe       = wr_strobe_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized scoreboard bench for spi_peripheral against a frame-level register model.
module tb_spi_peripheral;
  import spi_regs_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_peripheral_if bus();

  spi_peripheral #(.MAX_ADDR(7'h04), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  model [5];
  logic [39:0] exp_q [$];

  function automatic logic [39:0] model_snap();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [39:0] dut_snap();
    return {bus.pwm_duty_cycle, bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0,
            bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must correspond to a queued expected register image.
  always @(negedge clk) begin : monitor
    logic [39:0] e;
    if (rst_n && bus.wr_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe with regs %0h expected none", dut_snap());
      end else begin
        e = exp_q.pop_front();
        check("strobe_regs", dut_snap(), e);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [31:0] bits, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.copi = bits[i];
      wait_clks(half);
      bus.sclk = 1'b1;
      wait_clks(half);
      bus.sclk = 1'b0;
    end
  endtask

  // Reference model: only a complete 16-bit write to an implemented address updates a register.
  task automatic expect_frame(input logic [31:0] bits, input int nbits);
    int addr;
    if (nbits == 16 && bits[15] == 1'b1) begin
      addr = int'(bits[14:8]);
      if (addr <= 4) begin
        model[addr] = bits[7:0];
        exp_q.push_back(model_snap());
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits, input int half,
                            input bit check_lat);
    int lat;
    @(negedge clk);
    bus.ncs = 1'b0;
    wait_clks(half);
    drive_bits(bits, nbits, half);
    wait_clks(half);
    expect_frame(bits, nbits);
    bus.ncs = 1'b1;
    if (check_lat) begin
      lat = 0;
      for (int e = 1; e <= 10; e++) begin
        @(posedge clk);
        #1;
        if (bus.wr_strobe) begin
          lat = e;
          break;
        end
      end
      check("write_latency", lat, 4);
    end
    wait_clks(8);
    check("regs_after_frame", dut_snap(), model_snap());
  endtask

  task automatic sclk_noise(input int n);
    for (int i = 0; i < n; i++) begin
      bus.copi = 1'($urandom);
      bus.sclk = ~bus.sclk;
      wait_clks($urandom_range(1, 3));
    end
    bus.sclk = 1'b0;
    wait_clks(4);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stimulus
    logic [15:0] frame;
    logic [31:0] bits;
    int nbits;
    int sel;

    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    bus.ncs  = 1'b1;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    rst_n    = 1'b0;
    wait_clks(3);
    check("reset_regs", dut_snap(), 40'h0);
    check("reset_strobe", bus.wr_strobe, 0);
    check("reset_state", bus.state, IDLE);
    rst_n = 1'b1;
    wait_clks(5);

    // Basic write at clk/8 with latency measurement
    send_frame(32'h80F0, 16, 4, 1'b1);

    // Per-address decode, values accumulate
    send_frame(32'h81AA, 16, 4, 1'b0);
    send_frame(32'h8255, 16, 4, 1'b0);
    send_frame(32'h830F, 16, 4, 1'b0);
    send_frame(32'h8480, 16, 4, 1'b0);

    // Rejected frames: read, bad address, short, long
    send_frame(32'h0480, 16, 4, 1'b0);
    send_frame(32'h8533, 16, 4, 1'b0);
    send_frame(32'h8011 >> 1, 15, 4, 1'b0);
    send_frame({15'h0, 16'h8011, 1'b1}, 17, 4, 1'b0);

    // Reset in the middle of a write to the duty register
    @(negedge clk);
    bus.ncs = 1'b0;
    wait_clks(4);
    drive_bits(32'h84, 8, 4);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check("async_reset_regs", dut_snap(), model_snap());
    check("async_reset_strobe", bus.wr_strobe, 0);
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(6);
    check("idle_after_reset_ncs_low", bus.state, IDLE);
    drive_bits(32'h77, 8, 4);
    wait_clks(4);
    bus.ncs = 1'b1;
    wait_clks(8);
    check("no_write_after_abort", dut_snap(), model_snap());
    send_frame(32'h8233, 16, 4, 1'b0);

    // sclk noise with ncs high, then a minimum-timing write
    sclk_noise(20);
    check("regs_after_noise", dut_snap(), model_snap());
    send_frame(32'h8440, 16, 2, 1'b1);
    check("duty_min_timing", bus.pwm_duty_cycle, 8'h40);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      frame = {1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        nbits = 15;
        bits  = 32'(frame >> 1);
      end else if (sel == 1) begin
        nbits = 17;
        bits  = {15'h0, frame, 1'($urandom)};
      end else begin
        nbits = 16;
        bits  = 32'(frame);
      end
      if ($urandom_range(0, 4) == 0) sclk_noise($urandom_range(2, 8));
      send_frame(bits, nbits, $urandom_range(2, 4), 1'b0);
    end

    wait_clks(10);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
